// File: rtl/vtj1_iobus.sv
// CPU-to-I/O slot bridge: decodes a 4 KiB window into 16 slots and runs a fixed
// four-state access handshake. Optional debug taps enabled by VTJ1_IOBUS_DEBUG_EN.
module vtj1_iobus #(
  parameter logic [3:0]  IO_BASE   = 4'hB,
  parameter logic [15:0] SLOT_MASK = 16'hFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic [15:0]  cpu_adr,
  input  logic         cpu_we,
  input  logic [7:0]   cpu_wdat,
  output logic         cpu_ack,
  output logic [7:0]   cpu_rdat,
  output logic [7:0]   io_adr,
  output logic [7:0]   io_adr_d1,
  output logic [7:0]   io_wrt,
  output logic [15:0]  io_wen,
  input  logic [127:0] io_red,
  output logic [12:0]  dbg_last,
  output logic [15:0]  dbg_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t     state;
  logic [3:0] slot_q;
  logic [3:0] req_slot;
  logic       in_win;
  logic       hit;

  always_comb begin
    req_slot = cpu_adr[11:8];
    in_win   = (cpu_adr[15:12] == IO_BASE);
    hit      = in_win && SLOT_MASK[req_slot];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_q    <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdat  <= '0;
      io_adr    <= '0;
      io_adr_d1 <= '0;
      io_wrt    <= '0;
      io_wen    <= '0;
    end else begin
      io_adr_d1 <= io_adr;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              state  <= ACCESS;
              io_adr <= cpu_adr[7:0];
              io_wrt <= cpu_wdat;
              io_wen <= cpu_we ? (16'h0001 << req_slot) : '0;
              slot_q <= req_slot;
            end else begin
              // Misses complete immediately: no bus activity, fixed read value.
              state    <= ACK;
              cpu_ack  <= 1'b1;
              cpu_rdat <= in_win ? 8'h00 : 8'hFF;
            end
          end
        end
        ACCESS: begin
          io_wen <= '0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          cpu_rdat <= io_red[{slot_q, 3'b000} +: 8];
          cpu_ack  <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VTJ1_IOBUS_DEBUG_EN
  logic        we_q;
  logic        ack_set;
  logic [12:0] last_val;

  always_comb begin
    ack_set  = (state == CAPTURE) || ((state == IDLE) && cpu_req && !hit);
    last_val = (state == CAPTURE) ? {we_q, slot_q, io_adr} : {cpu_we, cpu_adr[11:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      dbg_last  <= '0;
      dbg_count <= '0;
    end else begin
      if (state == IDLE && cpu_req && hit)
        we_q <= cpu_we;
      if (ack_set) begin
        dbg_last  <= last_val;
        dbg_count <= dbg_count + 16'd1;
      end
    end
  end
`else
  assign dbg_last  = '0;
  assign dbg_count = '0;
`endif

endmodule
